// File: rtl/tiny_eth_pkg.sv
// rtl/tiny_eth_pkg.sv - shared constants for the tiny_eth MAC receive/transmit paths
package tiny_eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam int ERR_FCS      = 0;
    localparam int ERR_RUNT     = 1;
    localparam int ERR_OVERSIZE = 2;
    localparam int ERR_RXER     = 3;
    localparam int ERR_DRIBBLE  = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

endpackage

// File: rtl/tiny_eth_rx_deframer_if.sv
// rtl/tiny_eth_rx_deframer_if.sv - PHY receive side plus payload stream and frame status
interface tiny_eth_rx_deframer_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_en;
    logic              rx_er;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_err;
    logic              frame_good;
    logic              frame_bad;
    logic [4:0]        err_code;
    logic [10:0]       frame_len;

    modport master (
        output rx_data, rx_en, rx_er,
        input  out_data, out_valid, out_last, out_err,
        input  frame_good, frame_bad, err_code, frame_len
    );

    modport slave (
        input  rx_data, rx_en, rx_er,
        output out_data, out_valid, out_last, out_err,
        output frame_good, frame_bad, err_code, frame_len
    );
endinterface

// File: rtl/tiny_eth_crc32.sv
// rtl/tiny_eth_crc32.sv - byte-wide reflected CRC-32 next-state function
module tiny_eth_crc32
    import tiny_eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Eight serial LFSR steps, data LSB first
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) c = (c >> 1) ^ CRC_POLY;
            else                   c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/tiny_eth_rx_deframer.sv
// rtl/tiny_eth_rx_deframer.sv - MII/GMII receive deframer: preamble strip, FCS strip and checks
module tiny_eth_rx_deframer
    import tiny_eth_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CHECK_FCS = 1
) (
    input logic                   rx_clk,
    input logic                   rst,
    tiny_eth_rx_deframer_if.slave bus
);

    localparam logic [10:0] LEN_MIN = 11'(MIN_FRAME);
    localparam logic [10:0] LEN_MAX = 11'(MAX_FRAME);
    localparam logic [10:0] LEN_SAT = 11'(MAX_FRAME + 1);

    logic [1:0]       state_q, state_d;
    logic             armed_q, armed_d;
    logic             half_q, half_d;
    logic [3:0]       nib_q, nib_d;
    logic             pre_seen_q, pre_seen_d;
    logic [4:0][7:0]  line_q, line_d;
    logic [2:0]       fill_q, fill_d;
    logic [10:0]      len_q, len_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic             rxer_q, rxer_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_err_q, out_err_d;
    logic             frame_good_q, frame_good_d;
    logic             frame_bad_q, frame_bad_d;
    logic [4:0]       err_code_q, err_code_d;
    logic [10:0]      frame_len_q, frame_len_d;

    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic             half_nxt;
    logic [3:0]       nib_nxt;
    logic [4:0]       err_v;

    // Byte assembly: MII pairs nibbles low-first, GMII takes a byte per rx_en cycle
    if (DATA_W == 4) begin : g_mii
        assign rx_byte  = {bus.rx_data, nib_q};
        assign byte_vld = bus.rx_en & half_q;
        assign half_nxt = bus.rx_en & ~half_q;
        assign nib_nxt  = half_q ? nib_q : bus.rx_data;
    end else begin : g_gmii
        assign rx_byte  = bus.rx_data;
        assign byte_vld = bus.rx_en;
        assign half_nxt = 1'b0;
        assign nib_nxt  = nib_q;
    end

    tiny_eth_crc32 u_crc (
        .crc_in  (crc_q),
        .data_in (rx_byte),
        .crc_out (crc_next)
    );

    // Frame FSM, delay line, checks and registered output/status generation
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | ~bus.rx_en;
        half_d       = half_nxt;
        nib_d        = nib_nxt;
        pre_seen_d   = pre_seen_q;
        line_d       = line_q;
        fill_d       = fill_q;
        len_d        = len_q;
        crc_d        = crc_q;
        rxer_d       = rxer_q;
        out_data_d   = 8'h00;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        out_err_d    = 1'b0;
        frame_good_d = 1'b0;
        frame_bad_d  = 1'b0;
        err_code_d   = 5'd0;
        frame_len_d  = 11'd0;
        err_v        = 5'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_en) begin
                    pre_seen_d = 1'b0;
                    len_d      = 11'd0;
                    fill_d     = 3'd0;
                    rxer_d     = 1'b0;
                    // A frame already in flight when reset released is never joined mid-way
                    if (!armed_q || bus.rx_er) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_PREAMBLE;
                        if (byte_vld) begin
                            if (rx_byte == PREAMBLE_BYTE) pre_seen_d = 1'b1;
                            else                          state_d    = ST_DROP;
                        end
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!bus.rx_en) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_er) begin
                    state_d = ST_DROP;
                end else if (byte_vld) begin
                    if (rx_byte == PREAMBLE_BYTE) begin
                        pre_seen_d = 1'b1;
                    end else if (rx_byte == SFD_BYTE && pre_seen_q) begin
                        state_d = ST_DATA;
                        crc_d   = CRC_INIT;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_DATA: begin
                if (!bus.rx_en) begin
                    // End of frame: delay line head is the last payload byte, the rest is FCS
                    err_v[ERR_FCS]     = (CHECK_FCS != 0) && (crc_q != CRC_RESIDUE);
                    err_v[ERR_RUNT]    = (len_q < LEN_MIN) || (len_q <= 11'd4);
                    err_v[ERR_RXER]    = rxer_q;
                    err_v[ERR_DRIBBLE] = half_q;
                    if (fill_q == 3'd5) begin
                        out_valid_d = 1'b1;
                        out_data_d  = line_q[4];
                        out_last_d  = 1'b1;
                        out_err_d   = |err_v;
                    end
                    frame_good_d = ~|err_v;
                    frame_bad_d  = |err_v;
                    err_code_d   = err_v;
                    frame_len_d  = len_q;
                    state_d      = ST_IDLE;
                end else begin
                    if (bus.rx_er) rxer_d = 1'b1;
                    if (byte_vld) begin
                        crc_d  = crc_next;
                        line_d = {line_q[3:0], rx_byte};
                        fill_d = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
                        len_d  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
                        if (fill_q == 3'd5) begin
                            out_valid_d = 1'b1;
                            out_data_d  = line_q[4];
                        end
                        // Byte MAX_FRAME+1 terminates the frame early as oversize
                        if (len_q == LEN_MAX) begin
                            err_v[ERR_OVERSIZE] = 1'b1;
                            err_v[ERR_RXER]     = rxer_q | bus.rx_er;
                            out_last_d  = out_valid_d;
                            out_err_d   = out_valid_d;
                            frame_bad_d = 1'b1;
                            err_code_d  = err_v;
                            frame_len_d = LEN_SAT;
                            state_d     = ST_DROP;
                        end
                    end
                end
            end

            default: begin
                if (!bus.rx_en) state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            half_q       <= 1'b0;
            nib_q        <= 4'h0;
            pre_seen_q   <= 1'b0;
            line_q       <= '0;
            fill_q       <= 3'd0;
            len_q        <= 11'd0;
            crc_q        <= CRC_INIT;
            rxer_q       <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_err_q    <= 1'b0;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            err_code_q   <= 5'd0;
            frame_len_q  <= 11'd0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            half_q       <= half_d;
            nib_q        <= nib_d;
            pre_seen_q   <= pre_seen_d;
            line_q       <= line_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            rxer_q       <= rxer_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_err_q    <= out_err_d;
            frame_good_q <= frame_good_d;
            frame_bad_q  <= frame_bad_d;
            err_code_q   <= err_code_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_err    = out_err_q;
    assign bus.frame_good = frame_good_q;
    assign bus.frame_bad  = frame_bad_q;
    assign bus.err_code   = err_code_q;
    assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_tiny_eth_rx_deframer.sv
// tb/tb_tiny_eth_rx_deframer.sv - directed self-checking bench for MII and GMII deframer instances
module tb_tiny_eth_rx_deframer;

    localparam int NONE = -100;

    logic rx_clk = 1'b0;
    logic rst    = 1'b1;

    always #5 rx_clk = ~rx_clk;

    tiny_eth_rx_deframer_if #(.DATA_W(4)) if4 ();
    tiny_eth_rx_deframer_if #(.DATA_W(8)) if8 ();

    tiny_eth_rx_deframer #(.DATA_W(4)) dut4 (.rx_clk(rx_clk), .rst(rst), .bus(if4));
    tiny_eth_rx_deframer #(.DATA_W(8)) dut8 (.rx_clk(rx_clk), .rst(rst), .bus(if8));

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  frm[$];
    logic [9:0]  bq4[$], bq8[$], exp_b[$];
    logic [17:0] sq4[$], sq8[$], exp_s[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs4();
        return {3'b0, if4.out_data, if4.out_valid, if4.out_last, if4.out_err,
                if4.frame_good, if4.frame_bad, if4.err_code, if4.frame_len};
    endfunction

    function automatic logic [31:0] outs8();
        return {3'b0, if8.out_data, if8.out_valid, if8.out_last, if8.out_err,
                if8.frame_good, if8.frame_bad, if8.err_code, if8.frame_len};
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Payload seed+i followed by the FCS (complemented CRC, LSB byte first)
    task automatic build(input int n_pay, input int seed, input bit bad_fcs);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n_pay; i++) begin
            b = 8'(seed + i);
            frm.push_back(b);
            c = crc_upd(c, b);
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
        if (bad_fcs) frm[n_pay] = frm[n_pay] ^ 8'h01;
    endtask

    task automatic expect_beats(input int n, input int seed, input bit oe);
        for (int i = 0; i < n; i++)
            exp_b.push_back({(i == n - 1), (i == n - 1) & oe, 8'(seed + i)});
    endtask

    // Preamble, SFD and frm, then one idle cycle
    task automatic drive(input int w, input int er_at, input int rst_at, input bit odd_nib);
        logic [7:0] seq[$];
        for (int p = 0; p < 7; p++) seq.push_back(8'h55);
        seq.push_back(8'hD5);
        foreach (frm[j]) seq.push_back(frm[j]);
        for (int i = 0; i < seq.size(); i++) begin
            int pi;
            pi = i - 8;
            if (w == 8) begin
                @(posedge rx_clk); #1;
                if8.rx_en   = 1'b1;
                if8.rx_data = seq[i];
                if8.rx_er   = (pi == er_at);
                if (pi == rst_at) begin
                    rst = 1'b0;
                    #1 check("rst_mid_outputs", outs8(), 32'h0);
                end else if (pi == rst_at + 1) begin
                    rst = 1'b1;
                    bq8.delete();
                end
            end else begin
                @(posedge rx_clk); #1;
                if4.rx_en   = 1'b1;
                if4.rx_data = seq[i][3:0];
                if4.rx_er   = (pi == er_at);
                @(posedge rx_clk); #1;
                if4.rx_data = seq[i][7:4];
                if4.rx_er   = 1'b0;
            end
        end
        if (odd_nib) begin
            @(posedge rx_clk); #1;
            if4.rx_data = 4'hA;
        end
        @(posedge rx_clk); #1;
        if4.rx_en = 1'b0; if4.rx_er = 1'b0; if4.rx_data = '0;
        if8.rx_en = 1'b0; if8.rx_er = 1'b0; if8.rx_data = '0;
    endtask

    task automatic compare(input string tag, input int w);
        logic [9:0]  gb[$];
        logic [17:0] gs[$];
        int nbad;
        repeat (6) @(posedge rx_clk);
        if (w == 4) begin gb = bq4; gs = sq4; end
        else        begin gb = bq8; gs = sq8; end
        check({tag, "_nbeats"}, gb.size(), exp_b.size());
        nbad = 0;
        for (int i = 0; i < gb.size() && i < exp_b.size(); i++)
            if (gb[i] !== exp_b[i]) nbad++;
        check({tag, "_beat_errs"}, nbad, 0);
        check({tag, "_nstatus"}, gs.size(), exp_s.size());
        for (int i = 0; i < gs.size() && i < exp_s.size(); i++)
            check({tag, "_status"}, gs[i], exp_s[i]);
        bq4.delete(); sq4.delete(); bq8.delete(); sq8.delete();
        exp_b.delete(); exp_s.delete();
    endtask

    // Capture beats and status pulses away from the active edge
    always @(negedge rx_clk) begin
        if (if4.out_valid) bq4.push_back({if4.out_last, if4.out_err, if4.out_data});
        if (if4.frame_good || if4.frame_bad)
            sq4.push_back({if4.frame_good, if4.frame_bad, if4.err_code, if4.frame_len});
        if (if8.out_valid) bq8.push_back({if8.out_last, if8.out_err, if8.out_data});
        if (if8.frame_good || if8.frame_bad)
            sq8.push_back({if8.frame_good, if8.frame_bad, if8.err_code, if8.frame_len});
    end

    initial begin
        if4.rx_en = 1'b0; if4.rx_er = 1'b0; if4.rx_data = '0;
        if8.rx_en = 1'b0; if8.rx_er = 1'b0; if8.rx_data = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        check("reset_outputs_mii", outs4(), 32'h0);
        check("reset_outputs_gmii", outs8(), 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge rx_clk);

        build(60, 0, 0); drive(4, NONE, NONE, 0);
        expect_beats(60, 0, 0); exp_s.push_back({1'b1, 1'b0, 5'b00000, 11'd64});
        compare("mii_good", 4);

        build(60, 0, 1); drive(4, NONE, NONE, 0);
        expect_beats(60, 0, 1); exp_s.push_back({1'b0, 1'b1, 5'b00001, 11'd64});
        compare("mii_bad_fcs", 4);

        build(16, 0, 0);    drive(8, NONE, NONE, 0);
        build(60, 8'h40, 0); drive(8, NONE, NONE, 0);
        expect_beats(16, 0, 1);     exp_s.push_back({1'b0, 1'b1, 5'b00010, 11'd20});
        expect_beats(60, 8'h40, 0); exp_s.push_back({1'b1, 1'b0, 5'b00000, 11'd64});
        compare("gmii_runt_then_good", 8);

        build(60, 3, 0); drive(8, 30, NONE, 0);
        expect_beats(60, 3, 1); exp_s.push_back({1'b0, 1'b1, 5'b01000, 11'd64});
        compare("gmii_rx_er", 8);

        build(1596, 0, 0); drive(8, NONE, NONE, 0);
        expect_beats(1514, 0, 1); exp_s.push_back({1'b0, 1'b1, 5'b00100, 11'd1519});
        compare("gmii_oversize", 8);

        frm.delete(); frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
        drive(8, NONE, NONE, 0);
        exp_s.push_back({1'b0, 1'b1, 5'b00011, 11'd3});
        compare("gmii_tiny", 8);

        build(60, 0, 0);     drive(8, NONE, 10, 0);
        build(60, 8'h80, 0); drive(8, NONE, NONE, 0);
        expect_beats(60, 8'h80, 0); exp_s.push_back({1'b1, 1'b0, 5'b00000, 11'd64});
        compare("gmii_reset_mid", 8);

        build(60, 0, 0); drive(4, NONE, NONE, 1);
        expect_beats(60, 0, 1); exp_s.push_back({1'b0, 1'b1, 5'b10000, 11'd64});
        compare("mii_dribble", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tiny_eth_rx_deframer.md
# tiny_eth_rx_deframer

Parametrised receive front end for the tiny_eth MAC, sitting between the PHY receive interface and the MAC frame logic. It accepts MII (4-bit) or GMII (8-bit) receive data and strips preamble and SFD. It emits the frame payload as a byte stream with the 4-byte FCS removed, checks CRC-32, length and PHY errors, and reports a per-frame status pulse.

## Interface
Parameters:
- DATA_W, 4 — PHY data width; legal values 4 (MII, low nibble first) or 8 (GMII).
- MIN_FRAME, 64 — minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_FRAME, 1518 — maximum legal frame length in bytes, DA through FCS inclusive.
- CHECK_FCS, 1 — 1: FCS mismatch flagged; 0: CRC check disabled, FCS still stripped.

Ports:
- rx_clk  in  1  — receive clock; the only clock.
- rst  in  1  — asynchronous, active-low reset.
- rx_data  in  DATA_W  — PHY receive data.
- rx_en  in  1  — PHY receive data valid (RX_DV).
- rx_er  in  1  — PHY receive error.
- out_data  out  8  — payload byte.
- out_valid  out  1  — out_data valid this cycle; no backpressure.
- out_last  out  1  — final payload byte of the frame (byte before FCS).
- out_err  out  1  — qualifies out_last; frame is bad.
- frame_good  out  1  — one-cycle pulse: frame ended, no errors.
- frame_bad  out  1  — one-cycle pulse: frame ended with ≥1 error.
- err_code  out  5  — valid with frame_good/frame_bad. Bits: [0] FCS, [1] runt, [2] oversize, [3] rx_er, [4] dribble (odd nibble count, DATA_W=4 only).
- frame_len  out  11  — bytes after SFD including FCS, valid with status pulse; saturates at MAX_FRAME+1.

## Operation
- Byte assembly, DATA_W=4: two nibbles per byte, first nibble → bits [3:0]. DATA_W=8: one byte per rx_en cycle.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: on rx_en=1 → PREAMBLE, counters cleared.
- PREAMBLE:
  - byte 0x55 → stay.
  - byte 0xD5 after ≥1 0x55 → DATA; CRC register loaded with 0xFFFFFFFF.
  - any other byte, or rx_er=1 → DROP.
  - rx_en=0 → IDLE.
  - No status is issued from PREAMBLE.
- DATA:
  - Each completed byte goes into a 5-entry delay line, the CRC update and the length counter.
  - Once the line holds 5 bytes, each new byte pushes the oldest out as an out_valid beat.
  - rx_er=1 at any point sets the rx_er error bit; reception continues.
- End of frame, rx_en falling in DATA:
  - Head of the delay line is emitted with out_last=1. The 4 remaining bytes are the FCS and are discarded.
  - The status pulse is issued in the same cycle.
  - If frame_len ≤ 4: no beat is emitted; status only, with the runt bit set.
  - Next state IDLE.
- Checks at end of frame:
  - FCS: CRC-32 reflected (poly 0xEDB88320), init all-ones, run over all bytes including FCS. Final register ≠ 0xDEBB20E3 → FCS bit.
  - runt: frame_len < MIN_FRAME.
  - dribble: half byte pending when rx_en falls; the partial nibble is dropped.
- Oversize: on receipt of byte MAX_FRAME+1 in DATA:
  - Head byte emitted with out_last=1, out_err=1.
  - frame_bad pulses with the oversize bit and frame_len=MAX_FRAME+1.
  - State → DROP.
- DROP: ignore input until rx_en=0, then → IDLE. No further beats or status for that frame.
- out_err = out_last & (err_code≠0).

## Timing
- Reset values: every output 0, FSM IDLE, delay line empty.
- Reset release with rx_en=1: enter DROP, never resynchronise mid-frame.
- Assertion of rst mid-frame: outputs clear immediately; no status for the aborted frame.
- Outputs are registered. Byte k after SFD appears on out_data one cycle after byte k+5 completes.
- out_last and the status pulse appear one cycle after the first sampled rx_en=0.
- Beat spacing: DATA_W=8, up to one beat per cycle; DATA_W=4, at most one beat every 2 cycles.
- Back-to-back frames with a 1-cycle rx_en gap are handled without loss.
- frame_len is a counter saturating at MAX_FRAME+1; 11 bits cover MAX_FRAME ≤ 2046.

## Structure
- Shared tiny_eth_pkg:
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5.
  - CRC_POLY 32'hEDB88320, CRC_INIT all-ones, CRC_RESIDUE 32'hDEBB20E3.
  - err_code bit index localparams.
  - FSM state enum.
- Sub-module tiny_eth_crc32: byte-wide combinational next-CRC function (crc_in, data_in → crc_out), reused later by TX.

## Test plan
- DATA_W=4: 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS → 60 beats 0x00..0x3B, out_last on 0x3B, frame_good, frame_len=64, err_code=0.
- Same frame with one FCS bit flipped → identical beats, out_err=1, frame_bad, err_code=5'b00001.
- DATA_W=8: 20-byte frame (16 payload + FCS, valid CRC) → 16 beats, frame_bad, err_code=5'b00010, frame_len=20. Then a second 64-byte good frame after a 1-cycle gap → frame_good.
- DATA_W=8: rx_er for 1 cycle at payload byte 30 of a 64-byte frame → all 60 beats, frame_bad, err_code bit 3 only. 1600-byte frame → beat stream ends with out_last at byte 1514, frame_bad oversize, frame_len=1519, no further beats.
- rst asserted at payload byte 10 and released with rx_en still high → no status. Next frame with a 1-cycle gap is a 64-byte good frame → frame_good; DATA_W=4 odd nibble count → dribble bit set.
